game_state_ctrl: RTL

Game-level sequencer for the VGA asteroid game. It owns the title/play/pause/game-over state, the lives counter, the saturating score and high score, and the post-hit invulnerability window. It consumes per-pixel collision and score pulses from the asteroid and bullet instances, and the frame tick `move`. It drives `state` to the text renderer and pixel mux, and `frame_en` and `round_start` to the moving objects.

---
 rtl/game_state_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: game-level sequencer for the asteroid game.
// Owns title/play/pause/over state, lives, saturating score, high score,
// and the post-hit invulnerability window. All state advances only on
// pixpulse cycles; frame-based countdowns advance on sampled move ticks.
module game_state_ctrl #(
  parameter int START_LIVES      = 3,
  parameter int INVULN_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 90,
  parameter int N_COL            = 3,
  parameter int N_SC             = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pixpulse,
  input  logic             move,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             pause_btn,
  input  logic [N_COL-1:0] collision,
  input  logic [N_SC-1:0]  scored,
  output logic [1:0]       state,
  output logic [1:0]       lives,
  output logic [7:0]       score,
  output logic [7:0]       hi_score,
  output logic             frame_en,
  output logic             round_start,
  output logic             invuln,
  output logic             blink
);

  typedef enum logic [1:0] {
    S_TITLE = 2'b00,
    S_PLAY  = 2'b01,
    S_OVER  = 2'b10,
    S_PAUSE = 2'b11
  } state_t;

  state_t      st;
  logic [7:0]  invuln_cnt;
  logic [7:0]  hold_cnt;
  logic [3:0]  frame_cnt;
  logic [4:0]  btn_d;
  logic [4:0]  btn;
  logic [4:0]  rise;
  logic        hit;
  logic [7:0]  score_sum;

  // Count of asserted score sources this cycle (0..N_SC).
  function automatic logic [7:0] popcount(input logic [N_SC-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < N_SC; i++) begin
      c = c + {7'd0, v[i]};
    end
    return c;
  endfunction

  // Unsigned 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Bit order: 0 up, 1 down, 2 left, 3 right, 4 pause.
  assign btn       = {pause_btn, move_right, move_left, move_down, move_up};
  assign rise      = btn & ~btn_d;
  assign hit       = (|collision) && (invuln_cnt == 8'd0);
  assign score_sum = sat_add(score, popcount(scored));

  assign state    = st;
  assign frame_en = move & pixpulse & (st == S_PLAY);
  assign invuln   = (invuln_cnt != 8'd0);
  assign blink    = invuln & frame_cnt[3];

  // Game sequencer: button history, frame counter, and the state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_TITLE;
      lives       <= 2'd0;
      score       <= 8'd0;
      hi_score    <= 8'd0;
      invuln_cnt  <= 8'd0;
      hold_cnt    <= 8'd0;
      frame_cnt   <= 4'd0;
      btn_d       <= 5'd0;
      round_start <= 1'b0;
    end else begin
      // round_start lasts exactly one clk regardless of pixpulse.
      round_start <= 1'b0;
      if (pixpulse) begin
        btn_d <= btn;
        if (move) begin
          frame_cnt <= frame_cnt + 4'd1;
        end
        case (st)
          S_TITLE: begin
            if (|rise[3:0]) begin
              st          <= S_PLAY;
              lives       <= 2'(START_LIVES);
              score       <= 8'd0;
              invuln_cnt  <= 8'd0;
              round_start <= 1'b1;
            end
          end
          S_PLAY: begin
            score <= score_sum;
            if (hit && (lives == 2'd1)) begin
              // Fatal hit wins over a simultaneous pause request.
              lives    <= 2'd0;
              st       <= S_OVER;
              hold_cnt <= 8'(OVER_HOLD_FRAMES);
              hi_score <= (score_sum > hi_score) ? score_sum : hi_score;
            end else begin
              if (hit) begin
                lives      <= lives - 2'd1;
                invuln_cnt <= 8'(INVULN_FRAMES);
              end else if (move && (invuln_cnt != 8'd0)) begin
                invuln_cnt <= invuln_cnt - 8'd1;
              end
              if (rise[4]) begin
                st <= S_PAUSE;
              end
            end
          end
          S_PAUSE: begin
            if (rise[4]) begin
              st <= S_PLAY;
            end
          end
          S_OVER: begin
            if (hold_cnt != 8'd0) begin
              if (move) begin
                hold_cnt <= hold_cnt - 8'd1;
              end
            end else if (rise[3]) begin
              st          <= S_PLAY;
              lives       <= 2'(START_LIVES);
              score       <= 8'd0;
              invuln_cnt  <= 8'd0;
              round_start <= 1'b1;
            end else if (rise[0]) begin
              st <= S_TITLE;
            end
          end
          default: st <= S_TITLE;
        endcase
      end
    end
  end

endmodule
